// File: rtl/sqrt_iter_if.sv
// Operand/result handshake bundle for sqrt_iter.
// The controller drives start/num; the root unit returns busy/done/root/rem.
interface sqrt_iter_if #(
   parameter int WIDTH = 10
) ();
   localparam int ROOT_W = (WIDTH + 1) / 2;

   logic              start;
   logic [WIDTH-1:0]  num;
   logic              busy;
   logic              done;
   logic [ROOT_W:0]   root;
   logic [ROOT_W:0]   rem;

   modport master (output start, output num, input busy, input done, input root, input rem);
   modport slave  (input start, input num, output busy, output done, output root, output rem);
endinterface

// File: rtl/sqrt_iter.sv
// Multi-cycle integer square root, non-restoring radix-2, one root bit per clock.
// Optional macro SQRT_ROUND_EN: root is rounded to nearest instead of floored.
module sqrt_iter #(
   parameter int WIDTH = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   sqrt_iter_if.slave  bus
);
   localparam int ROOT_W = (WIDTH + 1) / 2;
   localparam int RAD_W  = 2 * ROOT_W;
   localparam int REM_W  = ROOT_W + 2;
   localparam int CNT_W  = $clog2(ROOT_W + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t              state;
   logic [RAD_W-1:0]    rad;
   logic [ROOT_W-1:0]   q;
   logic [REM_W-1:0]    r;
   logic [CNT_W-1:0]    cnt;
   logic                busy_q;
   logic                done_q;
   logic [ROOT_W:0]     root_q;
   logic [ROOT_W:0]     rem_q;

   logic                accept;
   logic [1:0]          pair;
   logic [REM_W-1:0]    shifted;
   logic [REM_W-1:0]    r_n;
   logic [ROOT_W-1:0]   q_n;
   logic [ROOT_W:0]     root_floor;
   logic [ROOT_W:0]     rem_fix;
   logic [ROOT_W:0]     root_fin;

   always_comb begin
      accept     = bus.start && (state == IDLE || state == FIN);
      pair       = rad[RAD_W-1 -: 2];
      shifted    = {r[REM_W-3:0], pair};
      if (!r[REM_W-1])
         r_n = shifted - {q, 2'b01};
      else
         r_n = shifted + {q, 2'b11};
      q_n        = ROOT_W'({q, ~r_n[REM_W-1]});
      root_floor = {1'b0, q_n};
      // The true remainder fits ROOT_W+1 bits, so the correction can be done modulo that width
      rem_fix    = r_n[ROOT_W:0] + (r_n[REM_W-1] ? {q_n, 1'b1} : '0);
`ifdef SQRT_ROUND_EN
      root_fin   = (rem_fix > root_floor) ? root_floor + (ROOT_W+1)'(1) : root_floor;
`else
      root_fin   = root_floor;
`endif
   end

   // Final result is computed on the last CALC edge so root/rem/done are all valid in the FIN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rad    <= '0;
         q      <= '0;
         r      <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         root_q <= '0;
         rem_q  <= '0;
      end else begin
         case (state)
            IDLE, FIN: begin
               done_q <= 1'b0;
               if (accept) begin
                  rad    <= RAD_W'(bus.num);
                  q      <= '0;
                  r      <= '0;
                  cnt    <= CNT_W'(ROOT_W - 1);
                  busy_q <= 1'b1;
                  state  <= CALC;
               end else begin
                  state  <= IDLE;
               end
            end
            CALC: begin
               rad <= rad << 2;
               q   <= q_n;
               r   <= r_n;
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state  <= FIN;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  root_q <= root_fin;
                  rem_q  <= rem_fix;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.root = root_q;
   assign bus.rem  = rem_q;
endmodule

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter: cycle-level reference model for WIDTH=10 plus directed checks at WIDTH=7.
// Expectations follow SQRT_ROUND_EN when it is defined.
module tb_sqrt_iter;
   localparam int W   = 10;
   localparam int RW  = (W + 1) / 2;
   localparam int W7  = 7;
   localparam int RW7 = (W7 + 1) / 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   cmp_en = 1'b0;

   sqrt_iter_if #(.WIDTH(W))  b10 ();
   sqrt_iter_if #(.WIDTH(W7)) b7 ();

   sqrt_iter #(.WIDTH(W))  dut   (.clk(clk), .rst_n(rst_n), .bus(b10.slave));
   sqrt_iter #(.WIDTH(W7)) dut_7 (.clk(clk), .rst_n(rst_n), .bus(b7.slave));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int isqrt(input int n);
      int s = 0;
      while ((s + 1) * (s + 1) <= n) s++;
      return s;
   endfunction

   function automatic int exp_root(input int n);
      int s = isqrt(n);
`ifdef SQRT_ROUND_EN
      if (n - s * s > s) s++;
`endif
      return s;
   endfunction

   // Reference: an accepted operand yields its result ROUND-trip ROOT_W+1 edges later
   int m_cyc = 0, m_root = 0, m_rem = 0, p_root = 0, p_rem = 0, m_n = 0;
   bit m_busy = 0, m_done = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc = 0; m_root = 0; m_rem = 0; m_busy = 0; m_done = 0;
      end else begin
         if (b10.start && (m_cyc == 0 || m_cyc == RW + 1)) begin
            m_n    = int'(b10.num);
            p_root = exp_root(m_n);
            p_rem  = m_n - isqrt(m_n) * isqrt(m_n);
            m_cyc  = 1;
         end else if (m_cyc >= 1 && m_cyc <= RW) begin
            m_cyc++;
         end else begin
            m_cyc = 0;
         end
         if (m_cyc == RW + 1) begin
            m_root = p_root;
            m_rem  = p_rem;
         end
         m_busy = (m_cyc >= 1 && m_cyc <= RW);
         m_done = (m_cyc == RW + 1);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_busy", int'(b10.busy), int'(m_busy));
         check("cyc_done", int'(b10.done), int'(m_done));
         check("cyc_root", int'(b10.root), m_root);
         check("cyc_rem",  int'(b10.rem),  m_rem);
      end
   end

   // Entered on a negedge; leaves on the negedge of the done cycle
   task automatic run10(input int n, input bit noise,
                        output int r, output int m, output int lat, output int bc);
      b10.start = 1'b1;
      b10.num   = W'(n);
      @(negedge clk);
      b10.start = 1'b0;
      lat = 1;
      bc  = 0;
      while (!b10.done && lat <= 20) begin
         if (b10.busy) bc++;
         if (noise) begin
            b10.start = 1'($urandom_range(0, 1));
            b10.num   = W'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      b10.start = 1'b0;
      check("done_seen", int'(b10.done), 1);
      r = int'(b10.root);
      m = int'(b10.rem);
   endtask

   task automatic run7(input int n, output int r, output int m, output int lat);
      b7.start = 1'b1;
      b7.num   = W7'(n);
      @(negedge clk);
      b7.start = 1'b0;
      lat = 1;
      while (!b7.done && lat <= 20) begin
         @(negedge clk);
         lat++;
      end
      check("done7_seen", int'(b7.done), 1);
      r = int'(b7.root);
      m = int'(b7.rem);
   endtask

   int r, m, lat, bc, dcount;
   int perm [1 << W];

   initial begin
      b10.start = 1'b0; b10.num = '0;
      b7.start  = 1'b0; b7.num  = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", int'(b10.busy), 0);
      check("rst_done", int'(b10.done), 0);
      check("rst_root", int'(b10.root), 0);
      check("rst_rem",  int'(b10.rem),  0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);

      run10(100, 0, r, m, lat, bc);
      check("r100", r, 10); check("m100", m, 0); check("lat100", lat, 6); check("busy100", bc, 5);
      run10(99, 0, r, m, lat, bc);
      check("r99", r, 9); check("m99", m, 18); check("lat99", lat, 6); check("busy99", bc, 5);
      repeat (2) @(negedge clk);

      run10(0, 0, r, m, lat, bc);
      check("r0", r, 0); check("m0", m, 0);
      run10(1023, 0, r, m, lat, bc);
`ifdef SQRT_ROUND_EN
      check("r1023", r, 32);
`else
      check("r1023", r, 31);
`endif
      check("m1023", m, 62);
      run10(90, 0, r, m, lat, bc);
      check("r90", r, 9); check("m90", m, 9);
      @(negedge clk);

      // A start during busy must be dropped
      b10.start = 1'b1; b10.num = W'(200);
      @(negedge clk); b10.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      b10.start = 1'b1; b10.num = W'(5);
      @(negedge clk); b10.start = 1'b0;
      dcount = 0;
      for (int i = 0; i < 15; i++) begin
         if (b10.done) begin
            dcount++;
            r = int'(b10.root);
            m = int'(b10.rem);
         end
         @(negedge clk);
      end
      check("ign_dones", dcount, 1); check("r200", r, 14); check("m200", m, 4);

      run10(144, 0, r, m, lat, bc);
      check("r144", r, 12); check("m144", m, 0);
      run10(50, 0, r, m, lat, bc);
      check("r50", r, 7); check("m50", m, 1); check("lat_b2b", lat, 6); check("busy_b2b", bc, 5);

      // Reset mid-operation clears outputs and abandons the result
      b10.start = 1'b1; b10.num = W'(400);
      @(negedge clk); b10.start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", int'(b10.busy), 0);
      check("mid_rst_done", int'(b10.done), 0);
      check("mid_rst_root", int'(b10.root), 0);
      check("mid_rst_rem",  int'(b10.rem),  0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         if (b10.done) dcount++;
         @(negedge clk);
      end
      check("rst_no_done", dcount, 0);
      run10(400, 0, r, m, lat, bc);
      check("r400", r, 20); check("m400", m, 0); check("lat400", lat, 6);

      run7(127, r, m, lat);
      check("r7_127", r, 11); check("m7_127", m, 6); check("lat7", lat, RW7 + 1);
      @(negedge clk);
      run7(120, r, m, lat);
`ifdef SQRT_ROUND_EN
      check("r7_120", r, 11);
`else
      check("r7_120", r, 10);
`endif
      check("m7_120", m, 20);
      @(negedge clk);

      for (int i = 0; i < (1 << W); i++) perm[i] = i;
      for (int i = (1 << W) - 1; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(0, i));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < (1 << W); i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
         run10(perm[i], 1, r, m, lat, bc);
         check("rnd_lat", lat, RW + 1);
      end
      repeat (3) @(negedge clk);
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
